// File: rtl/softmax_argmax_if.sv
// Handshake/bus bundle between the softmax output reader and its driver/consumer.
interface softmax_argmax_if #(
    parameter int unsigned N         = 10,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned IDX_W     = $clog2(N)
);
    logic                        start;
    logic signed [WORD_SIZE-1:0] dataIn [N-1:0];
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [IDX_W-1:0]            class_idx;
    logic signed [WORD_SIZE-1:0] class_prob;
    logic [IDX_W-1:0]            second_idx;
    logic [WORD_SIZE:0]          margin;

    // Driver side: issues start, presents the softmax vector, accepts results
    modport master (
        output start, dataIn, out_ready,
        input  busy, out_valid, class_idx, class_prob, second_idx, margin
    );

    // Reader side
    modport slave (
        input  start, dataIn, out_ready,
        output busy, out_valid, class_idx, class_prob, second_idx, margin
    );
endinterface

// File: rtl/softmax_argmax_reader.sv
// Captures the softmax output vector a fixed latency after start, scans it one
// word per cycle for top-1/top-2, and hands the result out over valid/ready.
module softmax_argmax_reader #(
    parameter int unsigned N         = 10,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned IDX_W     = $clog2(N)
) (
    input logic             clk,
    input logic             reset,
    softmax_argmax_if.slave bus
);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic signed [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, SCAN, DONE} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [IDX_W-1:0]            scan_idx;
    logic signed [WORD_SIZE-1:0] cap [N-1:0];
    logic signed [WORD_SIZE-1:0] best;
    logic signed [WORD_SIZE-1:0] second;
    logic [IDX_W-1:0]            best_idx;
    logic [IDX_W-1:0]            second_idx_r;

    logic                        capture_c;
    logic signed [WORD_SIZE-1:0] word_c;
    logic signed [WORD_SIZE-1:0] nxt_best_c;
    logic signed [WORD_SIZE-1:0] nxt_second_c;
    logic [IDX_W-1:0]            nxt_best_idx_c;
    logic [IDX_W-1:0]            nxt_second_idx_c;
    logic signed [WORD_SIZE:0]   diff_c;

    assign capture_c = (state == WAIT) && (cnt == CNT_W'(LATENCY - 1));

    // Top-2 update for the word under the scan pointer; strict compares keep ties on the lower index
    always_comb begin
        word_c           = cap[scan_idx];
        nxt_best_c       = best;
        nxt_best_idx_c   = best_idx;
        nxt_second_c     = second;
        nxt_second_idx_c = second_idx_r;
        if (scan_idx == '0) begin
            nxt_best_c       = word_c;
            nxt_best_idx_c   = '0;
            nxt_second_c     = MOST_NEG;
            nxt_second_idx_c = '0;
        end else if (word_c > best) begin
            nxt_second_c     = best;
            nxt_second_idx_c = best_idx;
            nxt_best_c       = word_c;
            nxt_best_idx_c   = scan_idx;
        end else if (word_c > second) begin
            nxt_second_c     = word_c;
            nxt_second_idx_c = scan_idx;
        end
        diff_c = {nxt_best_c[WORD_SIZE-1], nxt_best_c} - {nxt_second_c[WORD_SIZE-1], nxt_second_c};
    end

    // Capture buffer: the only place dataIn is sampled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) cap[i] <= '0;
        end else if (capture_c) begin
            cap <= bus.dataIn;
        end
    end

    // Control FSM with registered result fields and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            scan_idx       <= '0;
            best           <= '0;
            second         <= '0;
            best_idx       <= '0;
            second_idx_r   <= '0;
            bus.busy       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.class_idx  <= '0;
            bus.class_prob <= '0;
            bus.second_idx <= '0;
            bus.margin     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= WAIT;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (capture_c) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SCAN: begin
                    best         <= nxt_best_c;
                    best_idx     <= nxt_best_idx_c;
                    second       <= nxt_second_c;
                    second_idx_r <= nxt_second_idx_c;
                    if (scan_idx == IDX_W'(N - 1)) begin
                        state          <= DONE;
                        bus.out_valid  <= 1'b1;
                        bus.class_idx  <= nxt_best_idx_c;
                        bus.class_prob <= nxt_best_c;
                        bus.second_idx <= nxt_second_idx_c;
                        bus.margin     <= unsigned'(diff_c);
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_argmax_reader.sv
// Self-checking bench for softmax_argmax_reader: random jobs against a ranking model.
module tb_softmax_argmax_reader;
    localparam int N     = 10;
    localparam int W     = 16;
    localparam int LAT   = 8;
    localparam int IDX_W = $clog2(N);

    typedef logic signed [W-1:0] vec_t [N];

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [IDX_W-1:0]    exp_idx;
    logic signed [W-1:0] exp_prob;
    logic [IDX_W-1:0]    exp_sec;
    logic [W:0]          exp_margin;

    softmax_argmax_if #(.N(N), .WORD_SIZE(W), .IDX_W(IDX_W)) bus ();

    softmax_argmax_reader #(.N(N), .WORD_SIZE(W), .LATENCY(LAT), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Ranking model: winner is the first maximum; runner-up is the first maximum of the
    // remaining words, except that a runner-up equal to the most-negative value reports index 0.
    function automatic void model(input vec_t v, output int bi, output int si,
                                  output logic signed [W-1:0] bp, output logic [W:0] mg);
        logic signed [W-1:0] most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        bi = 0;
        for (int j = 1; j < N; j++) if (v[j] > v[bi]) bi = j;
        si = (bi == 0) ? 1 : 0;
        for (int j = 0; j < N; j++) if (j != bi && v[j] > v[si]) si = j;
        if (v[si] == most_neg) si = 0;
        bp = v[bi];
        mg = (W+1)'(int'(v[bi]) - int'(v[si]));
    endfunction

    task automatic drive_vec(input vec_t v);
        for (int j = 0; j < N; j++) bus.dataIn[j] = v[j];
    endtask

    task automatic drive_noise();
        for (int j = 0; j < N; j++) bus.dataIn[j] = W'($urandom);
    endtask

    // Output fields are compared against the model on every cycle the result is valid
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            check("class_idx", bus.class_idx, exp_idx);
            check("class_prob", bus.class_prob, exp_prob);
            check("second_idx", bus.second_idx, exp_sec);
            check("margin", bus.margin, exp_margin);
        end
    end

    // One job: entered and left at #1 after a rising edge
    task automatic run_job(input vec_t v, input int hold, input bit noisy);
        int bi, si, c;
        logic signed [W-1:0] bp;
        logic [W:0] mg;
        bit seen;
        model(v, bi, si, bp, mg);
        exp_idx    = IDX_W'(bi);
        exp_prob   = bp;
        exp_sec    = IDX_W'(si);
        exp_margin = mg;
        bus.start     = 1'b1;
        bus.out_ready = (hold == 0);
        if (noisy) drive_noise(); else drive_vec(v);
        c = 0;
        seen = 1'b0;
        while (!seen && c < LAT + N + 20) begin
            @(posedge clk);
            #1;
            c++;
            bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == LAT || !noisy) drive_vec(v); else drive_noise();
            if (bus.out_valid) seen = 1'b1;
            check("busy_active", bus.busy, 1);
        end
        check("valid_latency", c, LAT + N + 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_busy", bus.busy, 1);
            bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) drive_noise();
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("accept_valid", bus.out_valid, 0);
        check("accept_busy", bus.busy, 0);
        check("retain_idx", bus.class_idx, exp_idx);
        check("retain_margin", bus.margin, exp_margin);
        bus.start = 1'b0;
    endtask

    // Start a job, then assert reset k edges after the start sample
    task automatic reset_mid(input vec_t v, input int k);
        bus.start = 1'b1;
        drive_vec(v);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (k) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_class_idx", bus.class_idx, 0);
        check("rst_class_prob", bus.class_prob, 0);
        check("rst_second_idx", bus.second_idx, 0);
        check("rst_margin", bus.margin, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input vec_t v, input int ei, input int es, input int em);
        int bi, si;
        logic signed [W-1:0] bp;
        logic [W:0] mg;
        model(v, bi, si, bp, mg);
        check({name, "_idx"}, bi, ei);
        check({name, "_sec"}, si, es);
        check({name, "_margin"}, mg, em);
    endtask

    initial begin
        vec_t basic, ties, equal, extreme, neg, rv;
        int   mode;
        total = 0;
        bad   = 0;
        exp_idx = '0; exp_prob = '0; exp_sec = '0; exp_margin = '0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < N; j++) bus.dataIn[j] = '0;

        basic = '{16'h0010, 16'h0020, 16'h0300, 16'h0040, 16'h0120,
                  16'h0005, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        for (int j = 0; j < N; j++) begin
            ties[j]    = (j == 3 || j == 7) ? 16'h0200 : 16'h0010;
            equal[j]   = 16'h0100;
            extreme[j] = (j == 9) ? 16'h7FFF : 16'h8000;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.out_valid, 0);
        check("reset_class_idx", bus.class_idx, 0);
        check("reset_class_prob", bus.class_prob, 0);
        check("reset_second_idx", bus.second_idx, 0);
        check("reset_margin", bus.margin, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        pin("pin_basic", basic, 2, 4, 'h1E0);
        pin("pin_ties", ties, 3, 7, 0);
        pin("pin_equal", equal, 0, 1, 0);
        pin("pin_extreme", extreme, 9, 0, 'hFFFF);

        run_job(basic, 0, 1'b0);
        check("basic_prob_lit", bus.class_prob, 'h0300);
        reset_mid(basic, 3);
        run_job(basic, 0, 1'b0);
        reset_mid(basic, LAT + 3);
        run_job(ties, 0, 1'b0);
        run_job(equal, 0, 1'b0);
        run_job(extreme, 0, 1'b0);
        neg[0] = -16'sd5;
        for (int j = 1; j < N; j++) neg[j] = -W'($urandom_range(6, 30000));
        run_job(neg, 0, 1'b0);
        check("neg_idx_lit", bus.class_idx, 0);
        run_job(basic, 5, 1'b1);

        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 2);
            for (int j = 0; j < N; j++) begin
                if (mode == 0) rv[j] = W'($urandom);
                else if (mode == 1) rv[j] = W'($signed($urandom_range(0, 4)) - 2);
                else rv[j] = ($urandom_range(0, 3) == 0) ? 16'h8000 : W'($urandom_range(0, 1) ? 16'h7FFF : 16'h0000);
            end
            run_job(rv, (t < 15) ? 0 : $urandom_range(0, 3), t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
